// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants, types and helpers for the SHA-256/SHA-224
// chaining-state accumulator.
//   WORD_W / NUM_WORDS : word geometry of the 256-bit chaining value
//   IV_SHA256/IV_SHA224: initial hash values, H0 in the MSBs
//   state_t            : accumulator control states
//   get_word           : extract word i (H0 = word 0 in the MSBs)
//   byte_rev           : reverse byte order of a 256-bit value
package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;

    localparam logic [255:0] IV_SHA256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [255:0] IV_SHA224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] get_word(input logic [255:0] v,
                                                   input int unsigned i);
        return v[255 - WORD_W*i -: WORD_W];
    endfunction

    function automatic logic [255:0] byte_rev(input logic [255:0] v);
        logic [255:0] r;
        r = '0;
        for (int unsigned b = 0; b < 32; b++) begin
            r[8*b +: 8] = v[255 - 8*b -: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha256_word_add.sv
// sha256_word_add: one 32-bit modular adder lane of the chaining-state update.
//   a, b : addends (chaining word, compression word)
//   sum  : a + b mod 2^32, carry out discarded
module sha256_word_add
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/sha256_state_accum.sv
// sha256_state_accum: SHA-256/SHA-224 chaining-state accumulator.
// Loads the IV on start, adds each accepted compression result word-wise
// into H0..H7, and flags the final digest with digest_valid/digest_ack.
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   start         : begin a new message (reload IV), wins over blk_valid
//   blk_valid     : compression result on d is valid
//   blk_last      : accepted block is the final one of the message
//   d             : working variables a..h, word i at d[255-32*i -: 32]
//   blk_ready     : accumulator accepts a block this cycle
//   h_state       : chaining value H0..H7, same packing as d
//   blk_cnt       : blocks accepted in the current message
//   digest_valid  : h_state holds the final digest
//   digest_ack    : consumer has taken the digest
//   overflow      : sticky, MAX_BLOCKS reached without blk_last
// Optional (macro SHA256_TARGET_CMP_EN):
//   target        : 256-bit mining target
//   hit           : byte-reversed digest <= target, valid with digest_valid
module sha256_state_accum
    import sha256_pkg::*;
#(
    parameter  int IV_SEL     = 0,
    parameter  int MAX_BLOCKS = 2,
    localparam int CNT_W      = $clog2(MAX_BLOCKS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             blk_valid,
    input  logic             blk_last,
    input  logic [255:0]     d,
    output logic             blk_ready,
    output logic [255:0]     h_state,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             digest_valid,
    input  logic             digest_ack,
`ifdef SHA256_TARGET_CMP_EN
    input  logic [255:0]     target,
    output logic             hit,
`endif
    output logic             overflow
);

    localparam logic [255:0] IV = (IV_SEL == 1) ? IV_SHA224 : IV_SHA256;

    state_t             state, state_nx;
    logic [255:0]       sum;
    logic [255:0]       h_nx;
    logic [CNT_W-1:0]   cnt_nx;
    logic               dv_nx;
    logic               ov_nx;
`ifdef SHA256_TARGET_CMP_EN
    logic               hit_nx;
`endif

    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_add
        sha256_word_add u_add (
            .a   (get_word(h_state, i)),
            .b   (get_word(d, i)),
            .sum (sum[255 - WORD_W*i -: WORD_W])
        );
    end

    assign blk_ready = (state == ACCUM);

    always_comb begin
        state_nx = state;
        h_nx     = h_state;
        cnt_nx   = blk_cnt;
        dv_nx    = digest_valid;
        ov_nx    = overflow;
`ifdef SHA256_TARGET_CMP_EN
        hit_nx   = hit;
`endif
        if (start) begin
            state_nx = ACCUM;
            h_nx     = IV;
            cnt_nx   = '0;
            dv_nx    = 1'b0;
            ov_nx    = 1'b0;
`ifdef SHA256_TARGET_CMP_EN
            hit_nx   = 1'b0;
`endif
        end else begin
            case (state)
                ACCUM: begin
                    if (blk_valid) begin
                        h_nx   = sum;
                        cnt_nx = blk_cnt + CNT_W'(1);
                        // Last block, or the final permitted block without
                        // blk_last (forced termination, flagged by overflow).
                        if (blk_last || blk_cnt == CNT_W'(MAX_BLOCKS - 1)) begin
                            state_nx = DONE;
                            dv_nx    = 1'b1;
                            if (!blk_last) begin
                                ov_nx = 1'b1;
                            end
`ifdef SHA256_TARGET_CMP_EN
                            // Compare against the post-add value, which is
                            // what h_state shows once digest_valid is set.
                            hit_nx = (byte_rev(sum) <= target);
`endif
                        end
                    end
                end
                DONE: begin
                    if (digest_ack) begin
                        state_nx = IDLE;
                        dv_nx    = 1'b0;
`ifdef SHA256_TARGET_CMP_EN
                        hit_nx   = 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            h_state      <= IV;
            blk_cnt      <= '0;
            digest_valid <= 1'b0;
            overflow     <= 1'b0;
`ifdef SHA256_TARGET_CMP_EN
            hit          <= 1'b0;
`endif
        end else begin
            state        <= state_nx;
            h_state      <= h_nx;
            blk_cnt      <= cnt_nx;
            digest_valid <= dv_nx;
            overflow     <= ov_nx;
`ifdef SHA256_TARGET_CMP_EN
            hit          <= hit_nx;
`endif
        end
    end

endmodule

// File: tb/tb_sha256_state_accum.sv
// tb_sha256_state_accum: directed table, hand sequences and randomized
// stimulus for two accumulator instances (SHA-256 IV / 2 blocks and
// SHA-224 IV / 3 blocks) sharing the same inputs, each checked against a
// word-array reference model.
module tb_sha256_state_accum;

    logic         clk = 1'b0;
    logic         rst, start, blk_valid, blk_last, digest_ack;
    logic [255:0] d;

    logic         rdy0, dv0, ov0, rdy1, dv1, ov1;
    logic [255:0] h0, h1;
    logic [1:0]   cnt0, cnt1;
`ifdef SHA256_TARGET_CMP_EN
    logic [255:0] target;
    logic         hit0, hit1;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    sha256_state_accum #(.IV_SEL(0), .MAX_BLOCKS(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .blk_valid(blk_valid),
        .blk_last(blk_last), .d(d), .blk_ready(rdy0), .h_state(h0),
        .blk_cnt(cnt0), .digest_valid(dv0), .digest_ack(digest_ack),
`ifdef SHA256_TARGET_CMP_EN
        .target(target), .hit(hit0),
`endif
        .overflow(ov0)
    );

    sha256_state_accum #(.IV_SEL(1), .MAX_BLOCKS(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .blk_valid(blk_valid),
        .blk_last(blk_last), .d(d), .blk_ready(rdy1), .h_state(h1),
        .blk_cnt(cnt1), .digest_valid(dv1), .digest_ack(digest_ack),
`ifdef SHA256_TARGET_CMP_EN
        .target(target), .hit(hit1),
`endif
        .overflow(ov1)
    );

    // ---------------- reference model ----------------
    logic [31:0] ivw  [2][8];
    logic [31:0] mh   [2][8];
    int          mst  [2];     // 0 idle, 1 accumulating, 2 digest held
    int          mcnt [2];
    bit          mdv  [2];
    bit          mov  [2];
    bit          mhit [2];
    int          maxb [2] = '{2, 3};

    function automatic logic [255:0] pack(input int k);
        logic [255:0] r;
        r = '0;
        for (int w = 0; w < 8; w++) r[255 - 32*w -: 32] = mh[k][w];
        return r;
    endfunction

    function automatic logic [255:0] rev_bytes(input logic [255:0] v);
        logic [255:0] r;
        r = '0;
        for (int j = 0; j < 32; j++) r = {r[247:0], v[8*j +: 8]};
        return r;
    endfunction

    function automatic logic [255:0] iv_plus(input int k, input logic [31:0] a);
        logic [255:0] r;
        r = '0;
        for (int w = 0; w < 8; w++) r[255 - 32*w -: 32] = ivw[k][w] + a;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 8; w++) mh[k][w] = ivw[k][w];
            mst[k] = 0; mcnt[k] = 0; mdv[k] = 0; mov[k] = 0; mhit[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (start) begin
                for (int w = 0; w < 8; w++) mh[k][w] = ivw[k][w];
                mst[k] = 1; mcnt[k] = 0; mdv[k] = 0; mov[k] = 0; mhit[k] = 0;
            end else if (mst[k] == 1 && blk_valid) begin
                for (int w = 0; w < 8; w++) mh[k][w] = mh[k][w] + d[255 - 32*w -: 32];
                mcnt[k]++;
                if (blk_last || mcnt[k] == maxb[k]) begin
                    if (!blk_last) mov[k] = 1;
                    mdv[k] = 1;
                    mst[k] = 2;
`ifdef SHA256_TARGET_CMP_EN
                    mhit[k] = (rev_bytes(pack(k)) <= target);
`endif
                end
            end else if (mst[k] == 2 && digest_ack) begin
                mdv[k] = 0; mst[k] = 0; mhit[k] = 0;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_model();
        chk("m0.h_state", h0, pack(0));
        chk("m0.blk_cnt", 256'(cnt0), 256'(mcnt[0]));
        chk("m0.digest_valid", 256'(dv0), 256'(mdv[0]));
        chk("m0.overflow", 256'(ov0), 256'(mov[0]));
        chk("m0.blk_ready", 256'(rdy0), 256'(mst[0] == 1));
        chk("m1.h_state", h1, pack(1));
        chk("m1.blk_cnt", 256'(cnt1), 256'(mcnt[1]));
        chk("m1.digest_valid", 256'(dv1), 256'(mdv[1]));
        chk("m1.overflow", 256'(ov1), 256'(mov[1]));
        chk("m1.blk_ready", 256'(rdy1), 256'(mst[1] == 1));
`ifdef SHA256_TARGET_CMP_EN
        chk("m0.hit", 256'(hit0), 256'(mhit[0]));
        chk("m1.hit", 256'(hit1), 256'(mhit[1]));
`endif
    endtask

    task automatic drive(input bit st, input bit bv, input bit bl, input bit ak,
                         input logic [255:0] dd);
        start = st; blk_valid = bv; blk_last = bl; digest_ack = ak; d = dd;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    // ---------------- directed table (instance 0) ----------------
    typedef struct {
        bit           st, bv, bl, ak;
        logic [255:0] d;
        logic [255:0] eh;
        int           ec;
        bit           edv, eov, erdy;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input bit st, input bit bv, input bit bl, input bit ak,
                                input logic [255:0] dd, input logic [255:0] eh,
                                input int ec, input bit edv, input bit eov, input bit erdy);
        vec_t v;
        v.st = st; v.bv = bv; v.bl = bl; v.ak = ak; v.d = dd; v.eh = eh;
        v.ec = ec; v.edv = edv; v.eov = eov; v.erdy = erdy;
        return v;
    endfunction

    localparam logic [255:0] IV256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] IV224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
    localparam logic [255:0] ONES1 = {8{32'h00000001}};
    localparam logic [255:0] ALLF  = {256{1'b1}};

    initial begin
        logic [255:0] tmp;
        int idx;
        tmp = IV256;
        for (int w = 0; w < 8; w++) ivw[0][w] = tmp[255 - 32*w -: 32];
        tmp = IV224;
        for (int w = 0; w < 8; w++) ivw[1][w] = tmp[255 - 32*w -: 32];

        drive(0, 0, 0, 0, '0);
`ifdef SHA256_TARGET_CMP_EN
        target = ALLF;
`endif
        rst = 1'b1;
        model_reset();
        #1;
        chk("reset.h0", h0, IV256);
        chk("reset.h1", h1, IV224);
        chk("reset.cnt0", 256'(cnt0), 256'(0));
        chk("reset.dv0", 256'(dv0), 256'(0));
        chk("reset.ov0", 256'(ov0), 256'(0));
        chk("reset.rdy0", 256'(rdy0), 256'(0));
        @(negedge clk);
        rst = 1'b0;

        tbl[0]  = mk(1, 0, 0, 0, '0,    IV256,          0, 0, 0, 1);
        tbl[1]  = mk(0, 1, 1, 0, '0,    IV256,          1, 1, 0, 0);
        tbl[2]  = mk(0, 0, 0, 1, '0,    IV256,          1, 0, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0, '0,    IV256,          0, 0, 0, 1);
        tbl[4]  = mk(0, 1, 0, 0, ONES1, iv_plus(0, 1),  1, 0, 0, 1);
        tbl[5]  = mk(0, 1, 1, 0, ONES1, iv_plus(0, 2),  2, 1, 0, 0);
        tbl[6]  = mk(0, 0, 0, 1, '0,    iv_plus(0, 2),  2, 0, 0, 0);
        tbl[7]  = mk(1, 0, 0, 0, '0,    IV256,          0, 0, 0, 1);
        tbl[8]  = mk(0, 1, 1, 0, ALLF,  iv_plus(0, '1), 1, 1, 0, 0);
        tbl[9]  = mk(1, 0, 0, 0, '0,    IV256,          0, 0, 0, 1);
        tbl[10] = mk(0, 1, 0, 0, ONES1, iv_plus(0, 1),  1, 0, 0, 1);
        tbl[11] = mk(0, 1, 0, 0, ONES1, iv_plus(0, 2),  2, 1, 1, 0);
        tbl[12] = mk(0, 1, 1, 0, ONES1, iv_plus(0, 2),  2, 1, 1, 0);
        tbl[13] = mk(0, 0, 0, 1, '0,    iv_plus(0, 2),  2, 0, 1, 0);
        tbl[14] = mk(0, 1, 1, 0, ONES1, iv_plus(0, 2),  2, 0, 1, 0);
        tbl[15] = mk(1, 0, 0, 0, '0,    IV256,          0, 0, 0, 1);
        tbl[16] = mk(0, 1, 0, 0, ONES1, iv_plus(0, 1),  1, 0, 0, 1);
        tbl[17] = mk(1, 1, 0, 0, ONES1, IV256,          0, 0, 0, 1);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].st, tbl[i].bv, tbl[i].bl, tbl[i].ak, tbl[i].d);
            tick();
            chk($sformatf("tbl%0d.h", i), h0, tbl[i].eh);
            chk($sformatf("tbl%0d.cnt", i), 256'(cnt0), 256'(tbl[i].ec));
            chk($sformatf("tbl%0d.dv", i), 256'(dv0), 256'(tbl[i].edv));
            chk($sformatf("tbl%0d.ov", i), 256'(ov0), 256'(tbl[i].eov));
            chk($sformatf("tbl%0d.rdy", i), 256'(rdy0), 256'(tbl[i].erdy));
        end

        // Two unit blocks: literal digest words, digest_valid only on the 2nd.
        drive(1, 0, 0, 0, '0);     tick();
        drive(0, 1, 0, 0, ONES1);  tick();
        chk("two.dv_after_first", 256'(dv0), 256'(0));
        drive(0, 1, 1, 0, ONES1);  tick();
        chk("two.H0", 256'(h0[255:224]), 256'(32'h6a09e669));
        chk("two.H3", 256'(h0[159:128]), 256'(32'ha54ff53c));
        chk("two.dv_after_second", 256'(dv0), 256'(1));
        drive(0, 0, 0, 1, '0);     tick();

        // Asynchronous reset in the middle of a message.
        drive(1, 0, 0, 0, '0);     tick();
        drive(0, 1, 0, 0, ONES1);  tick();
        drive(0, 0, 0, 0, '0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst.h0", h0, IV256);
        chk("arst.h1", h1, IV224);
        chk("arst.cnt0", 256'(cnt0), 256'(0));
        chk("arst.cnt1", 256'(cnt1), 256'(0));
        chk("arst.rdy0", 256'(rdy0), 256'(0));
        @(negedge clk);
        rst = 1'b0;

`ifdef SHA256_TARGET_CMP_EN
        target = ALLF;
        drive(1, 0, 0, 0, '0);     tick();
        drive(0, 1, 1, 0, '0);     tick();
        chk("cmp.hit_ones", 256'(hit1), 256'(1));
        drive(0, 0, 0, 1, '0);     tick();
        chk("cmp.hit_ack", 256'(hit1), 256'(0));
        chk("cmp.dv_ack", 256'(dv1), 256'(0));
        target = '0;
        drive(1, 0, 0, 0, '0);     tick();
        drive(0, 1, 1, 0, '0);     tick();
        chk("cmp.hit_zero", 256'(hit1), 256'(0));
        drive(0, 0, 0, 1, '0);     tick();
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [255:0] rd;
            for (int w = 0; w < 8; w++) rd[255 - 32*w -: 32] = $urandom;
            idx = int'($urandom_range(0, 3));
            if (idx == 0) rd = '0;
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, rd);
`ifdef SHA256_TARGET_CMP_EN
            for (int w = 0; w < 8; w++) target[255 - 32*w -: 32] = $urandom;
`endif
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
